// File: rtl/cwe1280_secure_reader.sv
// Access-controlled read responder for the cwe1280 protected register: only AUTH_ID gets data.
// Optional consecutive-denial lockout is enabled by defining LOCKOUT_EN.
module cwe1280_secure_reader #(
    parameter int                DATA_W      = 8,
    parameter int                ID_W        = 3,
    parameter logic [ID_W-1:0]   AUTH_ID     = 3'h4,
    parameter int                MAX_FAIL    = 3,
    parameter int                LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ID_W-1:0]   usr_id,
    input  logic [DATA_W-1:0] reg_data,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              busy,
    output logic              locked
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2,
        LOCK  = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   data_q;
    logic                granted_q;
    logic                granted;

    // Reject configurations that would make the lockout thresholds meaningless
    if (MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_bad_cfg
        $error("cwe1280_secure_reader: MAX_FAIL and LOCK_CYCLES must be >= 1");
    end

    // The decision uses only the ID latched at acceptance, never the live usr_id
    assign granted = (id_q == AUTH_ID);

`ifdef LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic [FAIL_W-1:0] fail_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              lock_done;
    logic              lock_trigger;

    assign lock_done    = (lock_cnt == LOCK_W'(LOCK_CYCLES - 1));
    assign lock_trigger = !granted_q && (fail_cnt == FAIL_W'(MAX_FAIL));

    // Denial counter updates in CHECK so RESP already sees the count including this request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            if (state == CHECK) begin
                if (granted) begin
                    fail_cnt <= '0;
                end else if (fail_cnt != FAIL_W'(MAX_FAIL)) begin
                    fail_cnt <= fail_cnt + FAIL_W'(1);
                end
            end
            if (state == LOCK) begin
                if (lock_done) begin
                    lock_cnt <= '0;
                    fail_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + LOCK_W'(1);
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            id_q      <= '0;
            data_q    <= '0;
            granted_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && rd_req) begin
                id_q <= usr_id;
            end
            if (state == CHECK) begin
                granted_q <= granted;
                data_q    <= granted ? reg_data : '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                next_state = RESP;
            end
            RESP: begin
`ifdef LOCKOUT_EN
                next_state = lock_trigger ? LOCK : IDLE;
`else
                next_state = IDLE;
`endif
            end
            LOCK: begin
`ifdef LOCKOUT_EN
                if (lock_done) begin
                    next_state = IDLE;
                end
`else
                next_state = IDLE;
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Response outputs are gated by state so nothing leaks outside the RESP cycle
    assign rd_ack  = (state == RESP);
    assign rd_data = (state == RESP) ? data_q : '0;
    assign rd_err  = (state == RESP) && !granted_q;
    assign busy    = (state != IDLE);

`ifdef LOCKOUT_EN
    assign locked = (state == LOCK);
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_cwe1280_secure_reader.sv
// Self-checking bench for cwe1280_secure_reader: table-driven reads plus multi-cycle corner cases.
// Lockout sequences are compiled in when LOCKOUT_EN is defined.
module tb_cwe1280_secure_reader;

    logic       clk;
    logic       rst_n;
    logic       rd_req;
    logic [2:0] usr_id;
    logic [7:0] reg_data;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       busy;
    logic       locked;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0] id;
        logic [2:0] late_id;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    cwe1280_secure_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .usr_id   (usr_id),
        .reg_data (reg_data),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .busy     (busy),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_idle_ack"},    32'(rd_ack),  32'd0);
        checkOutput({tag, "_idle_busy"},   32'(busy),    32'd0);
        checkOutput({tag, "_idle_data"},   32'(rd_data), 32'd0);
        checkOutput({tag, "_idle_err"},    32'(rd_err),  32'd0);
        checkOutput({tag, "_idle_locked"}, 32'(locked),  32'd0);
    endtask

    // One request: accept, CHECK, RESP; returns one cycle after RESP
    task automatic applyStimulus(input string tag, input logic [2:0] id, input logic [2:0] late_id,
                                 input logic [7:0] data, input logic [7:0] exp_data, input logic exp_err);
        rd_req   = 1'b1;
        usr_id   = id;
        reg_data = data;
        step();
        rd_req = 1'b0;
        usr_id = late_id;
        checkOutput({tag, "_chk_busy"}, 32'(busy),    32'd1);
        checkOutput({tag, "_chk_ack"},  32'(rd_ack),  32'd0);
        checkOutput({tag, "_chk_data"}, 32'(rd_data), 32'd0);
        checkOutput({tag, "_chk_err"},  32'(rd_err),  32'd0);
        step();
        reg_data = ~data;
        #1;
        checkOutput({tag, "_rsp_ack"},  32'(rd_ack),  32'd1);
        checkOutput({tag, "_rsp_data"}, 32'(rd_data), 32'(exp_data));
        checkOutput({tag, "_rsp_err"},  32'(rd_err),  32'(exp_err));
        checkOutput({tag, "_rsp_busy"}, 32'(busy),    32'd1);
        step();
    endtask

    initial begin
        int ack_seen;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rd_req   = 1'b0;
        usr_id   = 3'd0;
        reg_data = 8'h00;

        // late_id is driven after acceptance and must never affect the decision
        vecs[0] = '{id: 3'd4, late_id: 3'd3, data: 8'hAB, exp_data: 8'hAB, exp_err: 1'b0};
        vecs[1] = '{id: 3'd3, late_id: 3'd4, data: 8'hCD, exp_data: 8'h00, exp_err: 1'b1};
        vecs[2] = '{id: 3'd4, late_id: 3'd0, data: 8'h00, exp_data: 8'h00, exp_err: 1'b0};
        vecs[3] = '{id: 3'd0, late_id: 3'd4, data: 8'hFF, exp_data: 8'h00, exp_err: 1'b1};
        vecs[4] = '{id: 3'd7, late_id: 3'd4, data: 8'h55, exp_data: 8'h00, exp_err: 1'b1};
        vecs[5] = '{id: 3'd4, late_id: 3'd7, data: 8'hFF, exp_data: 8'hFF, exp_err: 1'b0};
        vecs[6] = '{id: 3'd5, late_id: 3'd4, data: 8'h12, exp_data: 8'h00, exp_err: 1'b1};
        vecs[7] = '{id: 3'd4, late_id: 3'd5, data: 8'h3C, exp_data: 8'h3C, exp_err: 1'b0};

        #2;
        checkIdle("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        checkIdle("post_reset");

        $display("[TB] table-driven reads");
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].id, vecs[i].late_id,
                          vecs[i].data, vecs[i].exp_data, vecs[i].exp_err);
            checkIdle($sformatf("vec%0d", i));
        end

        $display("[TB] second request during CHECK is dropped");
        rd_req   = 1'b1;
        usr_id   = 3'd4;
        reg_data = 8'h5A;
        step();
        checkOutput("drop_chk_busy", 32'(busy), 32'd1);
        step();
        rd_req = 1'b0;
        checkOutput("drop_rsp_ack",  32'(rd_ack),  32'd1);
        checkOutput("drop_rsp_data", 32'(rd_data), 32'h5A);
        checkOutput("drop_rsp_busy", 32'(busy),    32'd1);
        ack_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rd_ack === 1'b1) ack_seen++;
        end
        checkOutput("drop_extra_acks", 32'(ack_seen), 32'd0);
        checkIdle("drop");

        $display("[TB] three consecutive denials");
        applyStimulus("den1", 3'd3, 3'd3, 8'h11, 8'h00, 1'b1);
        checkIdle("den1");
        applyStimulus("den2", 3'd3, 3'd3, 8'h22, 8'h00, 1'b1);
        checkIdle("den2");
        applyStimulus("den3", 3'd3, 3'd3, 8'h33, 8'h00, 1'b1);
`ifdef LOCKOUT_EN
        ack_seen = 0;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("lock_locked_%0d", i), 32'(locked), 32'd1);
            checkOutput($sformatf("lock_busy_%0d", i),   32'(busy),   32'd1);
            if (rd_ack === 1'b1) ack_seen++;
            rd_req = 1'b1;
            usr_id = 3'd4;
            step();
        end
        rd_req = 1'b0;
        checkOutput("lock_acks", 32'(ack_seen), 32'd0);
        checkIdle("lock_exit");
        applyStimulus("after_lock", 3'd4, 3'd4, 8'hA5, 8'hA5, 1'b0);
        checkIdle("after_lock");
`else
        checkIdle("den3");
`endif

        $display("[TB] reset during CHECK");
        rd_req   = 1'b1;
        usr_id   = 3'd4;
        reg_data = 8'h77;
        step();
        rd_req = 1'b0;
        checkOutput("rst_chk_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkIdle("rst_chk");
        step();
        checkIdle("rst_chk_held");
        rst_n = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rd_ack === 1'b1) ack_seen++;
        end
        checkOutput("rst_chk_acks", 32'(ack_seen), 32'd0);
        applyStimulus("rst_chk_fresh", 3'd4, 3'd1, 8'h99, 8'h99, 1'b0);
        checkIdle("rst_chk_fresh");

`ifdef LOCKOUT_EN
        $display("[TB] reset during LOCK");
        applyStimulus("rl1", 3'd6, 3'd6, 8'h01, 8'h00, 1'b1);
        applyStimulus("rl2", 3'd6, 3'd6, 8'h02, 8'h00, 1'b1);
        applyStimulus("rl3", 3'd6, 3'd6, 8'h03, 8'h00, 1'b1);
        step();
        step();
        checkOutput("rst_lock_locked", 32'(locked), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkIdle("rst_lock");
        step();
        rst_n = 1'b1;
        step();
        checkIdle("rst_lock_rel");
        applyStimulus("rst_lock_fresh", 3'd4, 3'd2, 8'hE1, 8'hE1, 1'b0);
        checkIdle("rst_lock_fresh");
`endif

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
